// File: rtl/dct_block_sched.sv
`default_nettype none
// ============================================================================
// Module      : dct_block_sched
// Description : Block scheduler for a two-stage 8x8 DCT. Accepts eight
//               input rows per block, issues delayed stage-1 column writes,
//               checks stage-1 sequencing, then streams the eight transposed
//               columns to stage 2 under valid/ready flow control.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PIPE_LAT     cycles from row handshake to its stage-1 write (1..4)
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     row offered              in_ready     row accepted
//   s1_start     block-start pulse        s1_wr_en_col stage-1 column write
//   s1_col_done  stage-1 at last column   tb_rd_idx    transpose read index
//   out_valid    column to stage 2        out_ready    stage 2 accepts
//   out_last     column 7 presented       block_done   block complete pulse
//   busy         not idle                 err          sticky sequencing error
//   blk_cnt      16-bit completed-block count (DCT_SCHED_STATS_EN only)
// Build option
//   DCT_SCHED_STATS_EN  adds the blk_cnt output port
// ============================================================================
module dct_block_sched #(
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        s1_start,
  output logic        s1_wr_en_col,
  input  logic        s1_col_done,
  output logic [2:0]  tb_rd_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        block_done,
  output logic        busy,
  output logic        err
`ifdef DCT_SCHED_STATS_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_fill    = 2'd1;
  localparam logic [1:0] c_wait_s1 = 2'd2;
  localparam logic [1:0] c_read    = 2'd3;

  logic [1:0]          r_state;
  logic [3:0]          r_row_cnt;
  logic [3:0]          r_wr_cnt;
  logic [2:0]          r_rd_idx;
  logic [PIPE_LAT-1:0] r_dl_wr;
  logic [PIPE_LAT-1:0] r_dl_first;
  logic                r_block_done;
  logic                r_err;

  logic w_accept;
  logic w_first_row;
  logic w_col_hs;
  logic w_eighth_wr;

  // Combinational decodes of registered state only.
  assign in_ready  = (r_state == c_idle) ||
                     ((r_state == c_fill) && (r_row_cnt < 4'd8));
  assign out_valid = (r_state == c_read);
  assign out_last  = (r_state == c_read) && (r_rd_idx == 3'd7);
  assign busy      = (r_state != c_idle);

  assign w_accept    = in_valid && in_ready;
  assign w_first_row = w_accept && (r_state == c_idle);
  assign w_col_hs    = out_valid && out_ready;

  // The write that brings the block's write count to eight.
  assign w_eighth_wr = s1_wr_en_col && (r_wr_cnt == 4'd7);

  // Write enable and start pulse come straight off the delay-line tail,
  // so both are flop outputs.
  assign s1_wr_en_col = r_dl_wr[PIPE_LAT-1];
  assign s1_start     = r_dl_first[PIPE_LAT-1];
  assign tb_rd_idx    = r_rd_idx;
  assign block_done   = r_block_done;
  assign err          = r_err;

  // Delay line: one bit marks an accepted row, a parallel bit tags row 0 so
  // the start pulse lines up with that row's write. Shifts in every state.
  if (PIPE_LAT == 1) begin : g_dl_single
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dl_wr    <= '0;
        r_dl_first <= '0;
      end else begin
        r_dl_wr    <= w_accept;
        r_dl_first <= w_first_row;
      end
    end
  end else begin : g_dl_multi
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dl_wr    <= '0;
        r_dl_first <= '0;
      end else begin
        r_dl_wr    <= {r_dl_wr[PIPE_LAT-2:0], w_accept};
        r_dl_first <= {r_dl_first[PIPE_LAT-2:0], w_first_row};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_idle;
      r_row_cnt    <= 4'd0;
      r_wr_cnt     <= 4'd0;
      r_rd_idx     <= 3'd0;
      r_block_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_block_done <= 1'b0;

      // Stage-1 sequencing check: s1_col_done must coincide exactly with
      // the eighth write. The error is sticky and never stalls the FSM.
      if (s1_wr_en_col) begin
        if (r_wr_cnt == 4'd7) begin
          if (!s1_col_done) begin
            r_err <= 1'b1;
          end
        end else if (s1_col_done) begin
          r_err <= 1'b1;
        end
        if (r_wr_cnt != 4'd8) begin
          r_wr_cnt <= r_wr_cnt + 4'd1;
        end
      end

      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_state   <= c_fill;
            r_row_cnt <= 4'd1;
          end
        end
        c_fill: begin
          if (w_accept) begin
            r_row_cnt <= r_row_cnt + 4'd1;
            if (r_row_cnt == 4'd7) begin
              r_state <= c_wait_s1;
            end
          end
        end
        c_wait_s1: begin
          // Advance on the eighth write even on a mismatch; err records it.
          if (w_eighth_wr) begin
            r_state  <= c_read;
            r_rd_idx <= 3'd0;
          end
        end
        c_read: begin
          if (w_col_hs) begin
            if (r_rd_idx == 3'd7) begin
              r_state      <= c_idle;
              r_block_done <= 1'b1;
              r_row_cnt    <= 4'd0;
              r_wr_cnt     <= 4'd0;
              r_rd_idx     <= 3'd0;
            end else begin
              r_rd_idx <= r_rd_idx + 3'd1;
            end
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

`ifdef DCT_SCHED_STATS_EN
  logic [15:0] r_blk_cnt;

  // Free-running block counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blk_cnt <= 16'd0;
    end else if (r_block_done) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule
`default_nettype wire
